// File: rtl/flow_update_engine.sv
`default_nettype none
// ============================================================================
// Module  : flow_update_engine
// Brief   : Read-modify-write of flow records (saturating pkt/byte counters)
//           with in-flight address hazard tracking.
// Revision: 1.0
// ============================================================================

`ifndef FLOW_RAM_ADDR_WIDTH
`define FLOW_RAM_ADDR_WIDTH 12
`endif
`ifndef FLOW_RAM_WORD_WIDTH
`define FLOW_RAM_WORD_WIDTH 72
`endif

module flow_update_engine #(
  parameter int ADDR_WIDTH   = `FLOW_RAM_ADDR_WIDTH,
  parameter int WORD_WIDTH   = `FLOW_RAM_WORD_WIDTH,
  parameter int SIZE_WIDTH   = 16,
  parameter int MAX_INFLIGHT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pkt_valid,
  output logic                  pkt_ready,
  input  logic [ADDR_WIDTH-1:0] pkt_addr,
  input  logic [SIZE_WIDTH-1:0] pkt_size,
  output logic                  sram_read_en,
  input  logic                  sram_read_ready,
  output logic [ADDR_WIDTH-1:0] sram_read_addr,
  input  logic [WORD_WIDTH-1:0] sram_read_data,
  input  logic                  sram_read_data_new,
  output logic                  sram_write_en,
  input  logic                  sram_write_ready,
  output logic [ADDR_WIDTH-1:0] sram_write_addr,
  output logic [WORD_WIDTH-1:0] sram_write_data,
  output logic                  idle,
  output logic                  resp_err
);

  localparam int c_IDX_W = $clog2(MAX_INFLIGHT);
  localparam int c_PTR_W = c_IDX_W + 1;

  logic [c_PTR_W-1:0]    r_alloc, r_issue, r_resp, r_wb;
  logic [ADDR_WIDTH-1:0] r_ent_addr [MAX_INFLIGHT];
  logic [SIZE_WIDTH-1:0] r_ent_size [MAX_INFLIGHT];
  logic [WORD_WIDTH-1:0] r_ent_data [MAX_INFLIGHT];

  logic                  r_rd_en;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [WORD_WIDTH-1:0] r_wr_data;
  logic                  r_resp_err;

  logic [c_PTR_W-1:0]    w_occ;
  logic [c_IDX_W-1:0]    w_off;
  logic                  w_hazard;
  logic                  w_accept, w_rd_fire, w_wr_fire, w_resp_ok, w_resp_stray;
  logic [c_IDX_W-1:0]    w_alloc_idx, w_resp_idx;
  logic [c_PTR_W-1:0]    w_alloc_nxt, w_issue_nxt, w_resp_nxt, w_wb_nxt;
  logic [32:0]           w_sum;
  logic [WORD_WIDTH-1:0] w_upd;
  logic                  w_rd_en_nxt, w_wr_en_nxt;
  logic [ADDR_WIDTH-1:0] w_rd_addr_nxt, w_wr_addr_nxt;
  logic [WORD_WIDTH-1:0] w_wr_data_nxt;

  // Occupancy never exceeds MAX_INFLIGHT, so its MSB alone means "full".
  assign w_occ       = r_alloc - r_wb;
  assign w_alloc_idx = r_alloc[c_IDX_W-1:0];
  assign w_resp_idx  = r_resp[c_IDX_W-1:0];

  always_comb begin
    w_hazard = 1'b0;
    w_off    = '0;
    for (int i = 0; i < MAX_INFLIGHT; i++) begin
      w_off = c_IDX_W'(i) - r_wb[c_IDX_W-1:0];
      if (({1'b0, w_off} < w_occ) && (r_ent_addr[i] == pkt_addr))
        w_hazard = 1'b1;
    end
  end

  assign pkt_ready    = !w_occ[c_IDX_W] && !w_hazard;
  assign w_accept     = pkt_valid && pkt_ready;
  assign w_rd_fire    = r_rd_en && sram_read_ready;
  assign w_wr_fire    = r_wr_en && sram_write_ready;
  assign w_resp_ok    = sram_read_data_new && (r_resp != r_issue);
  assign w_resp_stray = sram_read_data_new && (r_resp == r_issue);

  always_comb begin
    w_upd        = sram_read_data;
    w_sum        = {1'b0, sram_read_data[31:0]} + 33'(r_ent_size[w_resp_idx]);
    w_upd[63:32] = (&sram_read_data[63:32]) ? sram_read_data[63:32]
                                            : sram_read_data[63:32] + 32'd1;
    w_upd[31:0]  = w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0];
  end

  assign w_alloc_nxt = r_alloc + {{c_IDX_W{1'b0}}, w_accept};
  assign w_issue_nxt = r_issue + {{c_IDX_W{1'b0}}, w_rd_fire};
  assign w_resp_nxt  = r_resp  + {{c_IDX_W{1'b0}}, w_resp_ok};
  assign w_wb_nxt    = r_wb    + {{c_IDX_W{1'b0}}, w_wr_fire};

  // Registered outputs are preloaded from the entry each pointer will point
  // at next; entries written this very cycle are forwarded from their source.
  always_comb begin
    w_rd_en_nxt   = (w_issue_nxt != w_alloc_nxt);
    w_rd_addr_nxt = r_ent_addr[w_issue_nxt[c_IDX_W-1:0]];
    if (w_accept && (w_issue_nxt == r_alloc))
      w_rd_addr_nxt = pkt_addr;

    w_wr_en_nxt   = (w_wb_nxt != w_resp_nxt);
    w_wr_addr_nxt = r_ent_addr[w_wb_nxt[c_IDX_W-1:0]];
    w_wr_data_nxt = r_ent_data[w_wb_nxt[c_IDX_W-1:0]];
    if (w_resp_ok && (w_wb_nxt == r_resp))
      w_wr_data_nxt = w_upd;
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_ent_addr[w_alloc_idx] <= pkt_addr;
      r_ent_size[w_alloc_idx] <= pkt_size;
    end
    if (w_resp_ok)
      r_ent_data[w_resp_idx] <= w_upd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alloc    <= '0;
      r_issue    <= '0;
      r_resp     <= '0;
      r_wb       <= '0;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_resp_err <= 1'b0;
    end else begin
      r_alloc    <= w_alloc_nxt;
      r_issue    <= w_issue_nxt;
      r_resp     <= w_resp_nxt;
      r_wb       <= w_wb_nxt;
      r_rd_en    <= w_rd_en_nxt;
      r_wr_en    <= w_wr_en_nxt;
      if (w_rd_en_nxt)
        r_rd_addr <= w_rd_addr_nxt;
      if (w_wr_en_nxt) begin
        r_wr_addr <= w_wr_addr_nxt;
        r_wr_data <= w_wr_data_nxt;
      end
      if (w_resp_stray)
        r_resp_err <= 1'b1;
    end
  end

  assign sram_read_en    = r_rd_en;
  assign sram_read_addr  = r_rd_addr;
  assign sram_write_en   = r_wr_en;
  assign sram_write_addr = r_wr_addr;
  assign sram_write_data = r_wr_data;
  assign idle            = (r_alloc == r_wb);
  assign resp_err        = r_resp_err;

endmodule

`default_nettype wire

// File: tb/tb_flow_update_engine.sv
`default_nettype none
// ============================================================================
// Module  : tb_flow_update_engine
// Brief   : Directed self-checking bench with a 2-cycle-latency SRAM model.
// Revision: 1.0
// ============================================================================

module tb_flow_update_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [7:0]  pkt_addr;
  logic [15:0] pkt_size;
  logic        sram_read_en;
  logic        sram_read_ready;
  logic [7:0]  sram_read_addr;
  logic [71:0] sram_read_data;
  logic        sram_read_data_new;
  logic        sram_write_en;
  logic        sram_write_ready;
  logic [7:0]  sram_write_addr;
  logic [71:0] sram_write_data;
  logic        idle;
  logic        resp_err;

  logic [71:0] mem [256];
  logic        r_p1_v, r_rdn, stray;
  logic [7:0]  r_p1_a;
  int          rd_cnt = 0, wr_cnt = 0, cyc = 0;
  int          n_tests = 0, n_fail = 0;

  flow_update_engine #(
    .ADDR_WIDTH(8), .WORD_WIDTH(72), .SIZE_WIDTH(16), .MAX_INFLIGHT(16)
  ) dut (
    .clk(clk), .reset(reset),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_addr(pkt_addr), .pkt_size(pkt_size),
    .sram_read_en(sram_read_en), .sram_read_ready(sram_read_ready),
    .sram_read_addr(sram_read_addr), .sram_read_data(sram_read_data),
    .sram_read_data_new(sram_read_data_new),
    .sram_write_en(sram_write_en), .sram_write_ready(sram_write_ready),
    .sram_write_addr(sram_write_addr), .sram_write_data(sram_write_data),
    .idle(idle), .resp_err(resp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: read accepted at edge T returns data pulsed at edge T+2
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p1_v <= 1'b0;
      r_p1_a <= '0;
      r_rdn  <= 1'b0;
      sram_read_data <= '0;
    end else begin
      r_p1_v <= sram_read_en && sram_read_ready;
      r_p1_a <= sram_read_addr;
      r_rdn  <= r_p1_v;
      sram_read_data <= mem[r_p1_a];
    end
  end

  always @(posedge clk) begin
    if (!reset && sram_read_en && sram_read_ready) rd_cnt <= rd_cnt + 1;
    if (!reset && sram_write_en && sram_write_ready) begin
      mem[sram_write_addr] <= sram_write_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  assign sram_read_data_new = r_rdn | stray;

  task automatic check_value(input string tag, input logic [71:0] got,
                             input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [15:0] s);
    int n = 0;
    @(negedge clk);
    pkt_valid = 1'b1; pkt_addr = a; pkt_size = s;
    #1;
    while (!pkt_ready && n < 300) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 300) check_value("send_timeout", 72'd0, 72'd1);
    @(posedge clk); #1;
    pkt_valid = 1'b0;
  endtask

  task automatic wait_writes(input int target);
    int n = 0;
    while (wr_cnt < target && n < 1000) begin
      @(negedge clk); n++;
    end
    if (n >= 1000) check_value("write_timeout", 72'd0, 72'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rd0, wr0, accepted;
    int c [4];
    reset = 1'b1; pkt_valid = 1'b0; pkt_addr = '0; pkt_size = '0;
    sram_read_ready = 1'b1; sram_write_ready = 1'b1; stray = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    check_value("rst_pkt_ready", 72'(pkt_ready), 72'd1);
    check_value("rst_read_en", 72'(sram_read_en), 72'd0);
    check_value("rst_write_en", 72'(sram_write_en), 72'd0);
    check_value("rst_idle", 72'(idle), 72'd1);
    check_value("rst_resp_err", 72'(resp_err), 72'd0);
    check_value("rst_write_data", sram_write_data, 72'd0);
    reset = 1'b0;

    // single update
    mem[8'h12] = {8'hAB, 32'd5, 32'd1000};
    rd0 = rd_cnt; wr0 = wr_cnt;
    send_pkt(8'h12, 16'd64);
    wait_writes(wr0 + 1);
    check_value("single_rec", mem[8'h12], {8'hAB, 32'd6, 32'd1064});
    check_value("single_reads", 72'(rd_cnt - rd0), 72'd1);
    check_value("single_writes", 72'(wr_cnt - wr0), 72'd1);
    check_value("single_idle", 72'(idle), 72'd1);

    // saturation and exact-boundary no-saturation
    mem[8'h20] = {8'h5A, 32'hFFFF_FFFF, 32'hFFFF_FFF0};
    mem[8'h21] = {8'h00, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    wr0 = wr_cnt;
    send_pkt(8'h20, 16'h0040);
    send_pkt(8'h21, 16'h0001);
    wait_writes(wr0 + 2);
    check_value("sat_rec", mem[8'h20], {8'h5A, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    check_value("edge_rec", mem[8'h21], {8'h00, 32'hFFFF_FFFF, 32'hFFFF_FFFF});

    // same-address burst
    rd0 = rd_cnt; wr0 = wr_cnt;
    send_pkt(8'h07, 16'd10);
    @(negedge clk);
    pkt_valid = 1'b1; pkt_addr = 8'h07; pkt_size = 16'd10;
    #1;
    check_value("hazard_stall", 72'(pkt_ready), 72'd0);
    pkt_valid = 1'b0;
    send_pkt(8'h07, 16'd10);
    send_pkt(8'h07, 16'd10);
    wait_writes(wr0 + 3);
    check_value("burst_rec", mem[8'h07], {8'h00, 32'd3, 32'd30});
    check_value("burst_reads", 72'(rd_cnt - rd0), 72'd3);

    // throughput with distinct addresses
    wr0 = wr_cnt;
    for (int k = 0; k < 4; k++) begin
      send_pkt(8'h30 + 8'(k), 16'd1);
      c[k] = cyc;
    end
    check_value("throughput", 72'(c[3] - c[0]), 72'd3);
    wait_writes(wr0 + 4);
    check_value("tput_rec", mem[8'h33], {8'h00, 32'd1, 32'd1});

    // full buffer
    wr0 = wr_cnt; accepted = 0;
    sram_write_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      pkt_valid = 1'b1; pkt_addr = 8'h40 + 8'(k); pkt_size = 16'(k + 1);
      #1;
      if (!pkt_ready) break;
      @(posedge clk);
      accepted++;
    end
    check_value("full_accepted", 72'(accepted), 72'd16);
    check_value("full_ready", 72'(pkt_ready), 72'd0);
    repeat (10) @(negedge clk);
    #1;
    check_value("full_ready_hold", 72'(pkt_ready), 72'd0);
    pkt_valid = 1'b0;
    sram_write_ready = 1'b1;
    for (int k = accepted; k < 20; k++) send_pkt(8'h40 + 8'(k), 16'(k + 1));
    wait_writes(wr0 + 20);
    for (int k = 0; k < 20; k++)
      check_value($sformatf("full_rec%0d", k), mem[8'h40 + 8'(k)],
                  {8'h00, 32'd1, 32'(k + 1)});

    // stray response
    wr0 = wr_cnt;
    @(negedge clk); stray = 1'b1;
    @(negedge clk); stray = 1'b0;
    #1;
    check_value("stray_err", 72'(resp_err), 72'd1);
    repeat (5) @(negedge clk);
    check_value("stray_err_sticky", 72'(resp_err), 72'd1);
    check_value("stray_no_write", 72'(wr_cnt - wr0), 72'd0);
    check_value("stray_write_en", 72'(sram_write_en), 72'd0);

    // mid-operation asynchronous reset
    mem[8'h70] = {8'h11, 32'd2, 32'd3};
    sram_read_ready = 1'b0;
    for (int k = 0; k < 5; k++) send_pkt(8'h60 + 8'(k), 16'd8);
    @(negedge clk);
    check_value("inflight_busy", 72'(idle), 72'd0);
    check_value("inflight_rd_en", 72'(sram_read_en), 72'd1);
    #2 reset = 1'b1;
    #1;
    check_value("arst_pkt_ready", 72'(pkt_ready), 72'd1);
    check_value("arst_read_en", 72'(sram_read_en), 72'd0);
    check_value("arst_read_addr", 72'(sram_read_addr), 72'd0);
    check_value("arst_write_en", 72'(sram_write_en), 72'd0);
    check_value("arst_idle", 72'(idle), 72'd1);
    check_value("arst_resp_err", 72'(resp_err), 72'd0);
    @(negedge clk);
    reset = 1'b0;
    sram_read_ready = 1'b1;
    wr0 = wr_cnt;
    send_pkt(8'h70, 16'd5);
    wait_writes(wr0 + 1);
    check_value("post_rst_rec", mem[8'h70], {8'h11, 32'd3, 32'd8});
    check_value("post_rst_discard", mem[8'h60], 72'd0);
    check_value("post_rst_idle", 72'(idle), 72'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/flow_update_engine.md
# flow_update_engine

Read-modify-write engine between the packet parser and `sram_intf`. For each packet descriptor it reads the flow record, increments the packet and byte counters with saturation, and writes the record back. It tracks up to `MAX_INFLIGHT` outstanding updates and stalls any packet whose flow address is still in flight, so no update is ever lost to a read-after-write hazard.

## Interface
- `ADDR_WIDTH`, default `` `FLOW_RAM_ADDR_WIDTH ``: flow record address width.
- `WORD_WIDTH`, default `` `FLOW_RAM_WORD_WIDTH ``: record width, must be ≥ 64.
- `SIZE_WIDTH`, default 16: packet byte-size width, must be ≤ 32.
- `MAX_INFLIGHT`, default 16: tracked updates; power of 2, must be ≥ SRAM latency + 2.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `pkt_valid`  in  1  descriptor offered.
- `pkt_ready`  out  1  descriptor accepted when `pkt_valid && pkt_ready`.
- `pkt_addr`  in  ADDR_WIDTH  flow record address.
- `pkt_size`  in  SIZE_WIDTH  packet size in bytes.
- `sram_read_en`  out  1  read request.
- `sram_read_ready`  in  1  read accepted when `sram_read_en && sram_read_ready`.
- `sram_read_addr`  out  ADDR_WIDTH  read address.
- `sram_read_data`  in  WORD_WIDTH  returned record.
- `sram_read_data_new`  in  1  one-cycle pulse per returned read, in issue order.
- `sram_write_en`  out  1  write request.
- `sram_write_ready`  in  1  write accepted when `sram_write_en && sram_write_ready`.
- `sram_write_addr`  out  ADDR_WIDTH  write address.
- `sram_write_data`  out  WORD_WIDTH  updated record.
- `idle`  out  1  no entries in flight.
- `resp_err`  out  1  sticky: a response arrived with no read outstanding.

## Operation
- **Tracking buffer.** Circular buffer of `MAX_INFLIGHT` entries. Each entry holds addr, size and data.
- **Pointers** (log2(MAX_INFLIGHT)+1 bits each, wrap naturally):
  - `alloc`: next free entry.
  - `issue`: next entry to read.
  - `resp`: next entry awaiting data.
  - `wb`: next entry to write back.
  - Ordering invariant: wb ≤ resp ≤ issue ≤ alloc. Occupancy = alloc − wb.
- **Accept.** `pkt_ready` = (occupancy < MAX_INFLIGHT) && !hazard.
  - Hazard = `pkt_addr` equals the addr of any entry in [wb, alloc).
  - On accept, write the entry at `alloc` and increment `alloc`.
- **Read issue.** `sram_read_en` = (issue ≠ alloc). `sram_read_addr` = entry[issue].addr.
  - Both are registered outputs: they hold stable until accepted, and `issue` increments on accept.
- **Response.** On `sram_read_data_new` with resp ≠ issue:
  - entry[resp].data = updated record; increment `resp`.
  - If resp = issue, drop the data and set `resp_err`.
- **Update arithmetic.** Record bits [63:32] are the packet count, bits [31:0] the byte count.
  - pkt' = (pkt = 2^32−1) ? pkt : pkt+1.
  - bytes' = min(bytes + zero-extended size, 2^32−1), computed in 33 bits.
  - Bits [WORD_WIDTH−1:64] pass through unchanged.
- **Write-back.** `sram_write_en` = (wb ≠ resp). Address and data come from entry[wb], are registered and hold stable until accepted. Increment `wb` on accept.
- **Hazard release.** The hazard clears the cycle after that address's write is accepted.
- **Simultaneous events** (accept, read accept, response, write accept in the same cycle) are all legal and each updates only its own pointer.
- **Reset.** All pointers = 0 and `resp_err` = 0. Outstanding work is discarded.

## Timing
- **Reset values:** `pkt_ready` = 1, `sram_read_en` = 0, `sram_write_en` = 0, `idle` = 1, `resp_err` = 0; addr/data outputs = 0.
- **Read issue:** a descriptor accepted at edge T → `sram_read_en` high after T (earliest read accept at T+1).
- **Write-back:** response at edge R → `sram_write_en` high after R with the updated data.
- **Hazard-stalled packet** on the same address: accepted no earlier than 1 cycle after the write-accept edge.
- **Throughput:** 1 update/cycle with no backpressure and no repeated addresses.
- **Backpressure:** `sram_read_ready` / `sram_write_ready` low may last any number of cycles. Responses are never backpressured; occupancy ≤ MAX_INFLIGHT guarantees storage for them.
- **`pkt_ready`** is combinational from `pkt_addr` and registered state. `idle` is registered-state only.

## Test plan
- **Single update.** Record at addr 0x12 = {pkt=5, bytes=1000}; send size 64 → written record {6, 1064}, exactly one read and one write, `idle` returns to 1.
- **Saturation.** pkt=0xFFFFFFFF, bytes=0xFFFFFFF0, size 0x40 → write {0xFFFFFFFF, 0xFFFFFFFF}; bits above 63 unchanged.
- **Same-address burst.** 3 back-to-back packets to addr 7, size 10, starting from {0,0} → `pkt_ready` low while addr 7 is in flight; final record {3, 30}.
- **Full buffer.** Hold `sram_write_ready` = 0 and send 20 distinct addresses with MAX_INFLIGHT = 16 → exactly 16 accepted, then `pkt_ready` = 0. Release → all 20 records updated.
- **Stray response.** Pulse `sram_read_data_new` while idle → `resp_err` = 1 and stays 1; no write issued.
- **Mid-operation reset.** Assert `reset` with 5 entries in flight → outputs return to reset values immediately (asynchronous); the next packet after reset completes normally.
